// File: rtl/transpose_stream_ctrl.sv
// Streaming tile transposer: collects a ROWS x COLS tile in row-major order,
// then emits its COLS x ROWS transpose in row-major order.
module transpose_stream_ctrl #(
   parameter int ROWS       = 4,
   parameter int COLS       = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic                         out_last,
   output logic                         tile_done
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t                         r_state;
   logic [RW-1:0]                  r_wr_r;
   logic [CW-1:0]                  r_wr_c;
   logic [RW-1:0]                  r_rd_i;
   logic [CW-1:0]                  r_rd_j;
   logic signed [DATA_WIDTH-1:0]   r_buf [ROWS][COLS];

   logic w_in_hs;
   logic w_out_hs;

   // Handshake-facing flags are gated by rst_n so they drop during reset.
   assign in_ready  = rst_n && (r_state == FILL);
   assign out_valid = rst_n && (r_state == DRAIN);
   assign out_last  = out_valid && (r_rd_i == R_LAST) && (r_rd_j == C_LAST);
   assign out_data  = r_buf[r_rd_i][r_rd_j];

   assign w_in_hs  = in_valid && in_ready;
   assign w_out_hs = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= FILL;
         r_wr_r    <= '0;
         r_wr_c    <= '0;
         r_rd_i    <= '0;
         r_rd_j    <= '0;
         tile_done <= 1'b0;
      end else begin
         tile_done <= 1'b0;
         case (r_state)
            FILL: begin
               if (w_in_hs) begin
                  if (r_wr_c == C_LAST) begin
                     r_wr_c <= '0;
                     if (r_wr_r == R_LAST) begin
                        r_wr_r  <= '0;
                        r_state <= DRAIN;
                     end else begin
                        r_wr_r <= r_wr_r + 1'b1;
                     end
                  end else begin
                     r_wr_c <= r_wr_c + 1'b1;
                  end
               end
            end
            DRAIN: begin
               // Row index is the fast counter so each column is read top to bottom.
               if (w_out_hs) begin
                  if (r_rd_i == R_LAST) begin
                     r_rd_i <= '0;
                     if (r_rd_j == C_LAST) begin
                        r_rd_j    <= '0;
                        r_state   <= FILL;
                        tile_done <= 1'b1;
                     end else begin
                        r_rd_j <= r_rd_j + 1'b1;
                     end
                  end else begin
                     r_rd_i <= r_rd_i + 1'b1;
                  end
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_in_hs) begin
         r_buf[r_wr_r][r_wr_c] <= in_data;
      end
   end

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Self-checking bench for transpose_stream_ctrl over several tile geometries,
// compared against a transpose model built from index arithmetic.
module tb_transpose_stream_ctrl;

   localparam int NI = 4;
   localparam int ROWS_OF [NI] = '{2, 2, 1, 3};
   localparam int COLS_OF [NI] = '{3, 2, 4, 1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic [NI-1:0]        in_valid, in_ready, out_valid, out_ready, out_last, tile_done;
   logic [NI-1:0][7:0]   in_data, out_data;

   int   checks   = 0;
   int   failures = 0;
   bit   done_pending [NI];
   logic [7:0] tile_q [$];

   transpose_stream_ctrl #(.ROWS(ROWS_OF[0]), .COLS(COLS_OF[0]), .DATA_WIDTH(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .out_last(out_last[0]), .tile_done(tile_done[0]));
   transpose_stream_ctrl #(.ROWS(ROWS_OF[1]), .COLS(COLS_OF[1]), .DATA_WIDTH(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .out_last(out_last[1]), .tile_done(tile_done[1]));
   transpose_stream_ctrl #(.ROWS(ROWS_OF[2]), .COLS(COLS_OF[2]), .DATA_WIDTH(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .out_last(out_last[2]), .tile_done(tile_done[2]));
   transpose_stream_ctrl #(.ROWS(ROWS_OF[3]), .COLS(COLS_OF[3]), .DATA_WIDTH(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
      .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
      .out_data(out_data[3]), .out_last(out_last[3]), .tile_done(tile_done[3]));

   // Full tile through instance k using tile_q as row-major input.
   // vmode: percent valid (100 = always, -1 = alternate 1/0); rmode: percent ready;
   // stall_idx: output index at which out_ready is held low for 3 cycles (-1 none).
   task automatic run_tile(input int k, input int vmode, input int rmode,
                           input int stall_idx, input string tag);
      int rows = ROWS_OF[k];
      int cols = COLS_OF[k];
      int n    = rows * cols;
      logic [7:0] exp_q [$];
      int idx = 0, cyc = 0, j = 0, stall = 0;
      for (int c = 0; c < cols; c++)
         for (int r = 0; r < rows; r++)
            exp_q.push_back(tile_q[r * cols + c]);

      while (idx < n && cyc < 2000) begin
         @(negedge clk);
         in_valid[k]  = (vmode < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < vmode);
         in_data[k]   = in_valid[k] ? tile_q[idx] : 8'($urandom);
         out_ready[k] = 1'($urandom_range(1));
         #1;
         checks++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s fill_flags k=%0d cyc=%0d in_ready=%b out_valid=%b required 1/0",
                     tag, k, cyc, in_ready[k], out_valid[k]);
         end
         checks++;
         if (tile_done[k] !== done_pending[k]) begin
            failures++;
            $display("FAIL %s fill_tile_done k=%0d cyc=%0d got=%b required=%b",
                     tag, k, cyc, tile_done[k], done_pending[k]);
         end
         done_pending[k] = 1'b0;
         if (in_valid[k] && in_ready[k]) idx++;
         cyc++;
      end
      checks++;
      if (idx != n) begin
         failures++;
         $display("FAIL %s fill_timeout k=%0d accepted=%0d required=%0d", tag, k, idx, n);
      end
      if (vmode == 100) begin
         checks++;
         if (cyc != n) begin
            failures++;
            $display("FAIL %s fill_cycles k=%0d got=%0d required=%0d", tag, k, cyc, n);
         end
      end

      cyc = 0;
      while (j < n && cyc < 2000) begin
         @(negedge clk);
         in_valid[k] = 1'($urandom_range(1));
         in_data[k]  = 8'($urandom);
         if (j == stall_idx && stall < 3) begin
            out_ready[k] = 1'b0;
            stall++;
         end else begin
            out_ready[k] = (rmode >= 100) || ($urandom_range(99) < rmode);
         end
         #1;
         checks++;
         if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s drain_flags k=%0d j=%0d out_valid=%b in_ready=%b required 1/0",
                     tag, k, j, out_valid[k], in_ready[k]);
         end
         checks++;
         if (out_data[k] !== exp_q[j]) begin
            failures++;
            $display("FAIL %s out_data k=%0d j=%0d got=%0d required=%0d",
                     tag, k, j, $signed(out_data[k]), $signed(exp_q[j]));
         end
         checks++;
         if (out_last[k] !== (j == n - 1)) begin
            failures++;
            $display("FAIL %s out_last k=%0d j=%0d got=%b required=%b",
                     tag, k, j, out_last[k], (j == n - 1));
         end
         checks++;
         if (tile_done[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s drain_tile_done k=%0d j=%0d got=%b required=0", tag, k, j, tile_done[k]);
         end
         if (out_valid[k] && out_ready[k]) j++;
         cyc++;
      end
      checks++;
      if (j != n) begin
         failures++;
         $display("FAIL %s drain_timeout k=%0d emitted=%0d required=%0d", tag, k, j, n);
      end
      done_pending[k] = 1'b1;
   endtask

   task automatic idle(input int k, input int ncyc, input string tag);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         in_valid[k]  = 1'b0;
         in_data[k]   = 8'($urandom);
         out_ready[k] = 1'($urandom_range(1));
         #1;
         checks++;
         if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_last[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_flags k=%0d in_ready=%b out_valid=%b out_last=%b required 1/0/0",
                     tag, k, in_ready[k], out_valid[k], out_last[k]);
         end
         checks++;
         if (tile_done[k] !== done_pending[k]) begin
            failures++;
            $display("FAIL %s idle_tile_done k=%0d c=%0d got=%b required=%b",
                     tag, k, c, tile_done[k], done_pending[k]);
         end
         done_pending[k] = 1'b0;
      end
   endtask

   task automatic load_seq(input int first, input int n);
      tile_q.delete();
      for (int v = 0; v < n; v++) tile_q.push_back(8'(first + v));
   endtask

   task automatic pulse_reset(input int k, input string tag);
      @(negedge clk);
      in_valid = '0;
      out_ready = '0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || out_last[k] !== 1'b0) begin
         failures++;
         $display("FAIL %s in_reset k=%0d in_ready=%b out_valid=%b out_last=%b required 0/0/0",
                  tag, k, in_ready[k], out_valid[k], out_last[k]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || tile_done[k] !== 1'b0) begin
         failures++;
         $display("FAIL %s after_reset k=%0d in_ready=%b out_valid=%b tile_done=%b required 1/0/0",
                  tag, k, in_ready[k], out_valid[k], tile_done[k]);
      end
      for (int i = 0; i < NI; i++) done_pending[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = '0; out_ready = '0; in_data = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (in_ready !== '0 || out_valid !== '0 || out_last !== '0 || tile_done !== '0) begin
         failures++;
         $display("FAIL reset_state in_ready=%b out_valid=%b out_last=%b tile_done=%b required all 0",
                  in_ready, out_valid, out_last, tile_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== '1 || out_valid !== '0) begin
         failures++;
         $display("FAIL reset_release in_ready=%b out_valid=%b required 1111/0000", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      load_seq(1, 6);
      run_tile(0, 100, 100, -1, "basic");
      idle(0, 2, "basic");
   endtask

   task automatic test_signed();
      tile_q.delete();
      tile_q.push_back(8'h80); tile_q.push_back(8'h7F);
      tile_q.push_back(8'hFF); tile_q.push_back(8'h00);
      run_tile(1, 100, 100, -1, "signed");
      idle(1, 2, "signed");
   endtask

   task automatic test_stall();
      load_seq(1, 6);
      run_tile(0, 100, 100, 1, "stall");
      idle(0, 2, "stall");
   endtask

   task automatic test_valid_toggle();
      load_seq(31, 6);
      run_tile(0, -1, 100, -1, "toggle");
      idle(0, 2, "toggle");
   endtask

   task automatic test_reset_fill();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         in_valid[0] = 1'b1;
         in_data[0]  = 8'(100 + c);
      end
      pulse_reset(0, "rst_fill");
      idle(0, 2, "rst_fill");
      load_seq(7, 6);
      run_tile(0, 100, 100, -1, "rst_fill");
      idle(0, 2, "rst_fill");
   endtask

   task automatic test_reset_drain();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in_valid[0]  = 1'b1;
         in_data[0]   = 8'(20 + c);
         out_ready[0] = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         in_valid[0]  = 1'b0;
         out_ready[0] = 1'b1;
         #1;
         checks++;
         if (out_valid[0] !== 1'b1 || out_data[0] !== 8'(20 + 3 * c)) begin
            failures++;
            $display("FAIL rst_drain pre_reset c=%0d out_valid=%b out_data=%0d required 1/%0d",
                     c, out_valid[0], out_data[0], 20 + 3 * c);
         end
      end
      pulse_reset(0, "rst_drain");
      idle(0, 3, "rst_drain");
      load_seq(50, 6);
      run_tile(0, 100, 100, -1, "rst_drain");
      idle(0, 2, "rst_drain");
   endtask

   task automatic test_back_to_back();
      load_seq(60, 6);
      run_tile(0, 100, 100, -1, "b2b_t1");
      load_seq(70, 6);
      run_tile(0, 100, 100, -1, "b2b_t2");
      idle(0, 2, "b2b");
   endtask

   task automatic test_degenerate();
      load_seq(81, 4);
      run_tile(2, 100, 100, -1, "row1");
      idle(2, 2, "row1");
      load_seq(91, 3);
      run_tile(3, 100, 100, -1, "col1");
      idle(3, 2, "col1");
   endtask

   task automatic test_random();
      for (int k = 0; k < NI; k++) begin
         for (int t = 0; t < 4; t++) begin
            tile_q.delete();
            for (int e = 0; e < ROWS_OF[k] * COLS_OF[k]; e++) tile_q.push_back(8'($urandom));
            run_tile(k, 30 + $urandom_range(70), 30 + $urandom_range(70), -1, "random");
         end
         idle(k, 2, "random");
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) done_pending[i] = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_stall();
      test_valid_toggle();
      test_reset_fill();
      test_reset_drain();
      test_back_to_back();
      test_degenerate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
